// File: rtl/decode_pkg.sv
// Shared MIPS-I encodings, the decoded control bundle and operand-use helpers
// for the decode_queue slice.
package decode_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_LBU      = 6'h24;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SW       = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_MUL   = 6'h02;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [4:0] RT_BLTZ = 5'h00;
  localparam logic [4:0] RT_BGEZ = 5'h01;

  typedef struct packed {
    logic       alu_op;
    logic       unsigned_op;
    logic       imm_op;
    logic       byte_op;
    logic       shift_op;
    logic       mem_op;
    logic       write_op;
    logic       branch_op;
    logic       jump_op;
    logic       reg_jump_op;
    logic       nop;
    logic [5:0] op_type;
  } decode_bundle_t;

  // rt is a source for R-type, the two-register branches and stores.
  function automatic logic reads_rt(input logic [31:0] instr);
    logic [5:0] op;
    op = instr[31:26];
    return (op == OP_SPECIAL) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_SB) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational MIPS-I instruction-to-control-bundle decoder.
module decode_logic
  import decode_pkg::*;
(
  input  logic [31:0]    instr,
  output decode_bundle_t bundle
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] shamt;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rt     = instr[20:16];
  assign shamt  = instr[10:6];

  always_comb begin
    bundle = '0;
    case (opcode)
      OP_SPECIAL: begin
        bundle.op_type = funct;
        case (funct)
          FN_JR, FN_JALR: begin
            bundle.jump_op     = 1'b1;
            bundle.reg_jump_op = 1'b1;
          end
          FN_ADDU, FN_SUBU, FN_MULTU, FN_DIVU, FN_SLTU: begin
            bundle.alu_op      = 1'b1;
            bundle.unsigned_op = 1'b1;
          end
          FN_ADD, FN_SUB, FN_MULT, FN_DIV, FN_SLT,
          FN_AND, FN_OR, FN_XOR, FN_NOR: bundle.alu_op = 1'b1;
          FN_SRL, FN_SRA: begin
            bundle.alu_op   = 1'b1;
            bundle.imm_op   = 1'b1;
            bundle.shift_op = 1'b1;
          end
          // SLL with a zero shift amount is the canonical MIPS nop.
          FN_SLL: begin
            if (shamt != '0) begin
              bundle.alu_op   = 1'b1;
              bundle.imm_op   = 1'b1;
              bundle.shift_op = 1'b1;
            end else begin
              bundle.nop = 1'b1;
            end
          end
          FN_SLLV, FN_SRLV, FN_SRAV: begin
            bundle.alu_op   = 1'b1;
            bundle.shift_op = 1'b1;
          end
          default: bundle.nop = 1'b1;
        endcase
      end
      OP_SPECIAL2: begin
        bundle.op_type = opcode;
        if (funct == FN_MUL) bundle.alu_op = 1'b1;
        else                 bundle.nop    = 1'b1;
      end
      OP_REGIMM: begin
        bundle.op_type = {1'b0, rt};
        if (rt == RT_BGEZ || rt == RT_BLTZ) bundle.branch_op = 1'b1;
        else                                bundle.nop       = 1'b1;
      end
      OP_ADDIU, OP_SLTIU: begin
        bundle.op_type     = opcode;
        bundle.alu_op      = 1'b1;
        bundle.imm_op      = 1'b1;
        bundle.unsigned_op = 1'b1;
      end
      OP_ANDI, OP_SLTI, OP_ORI, OP_XORI: begin
        bundle.op_type = opcode;
        bundle.alu_op  = 1'b1;
        bundle.imm_op  = 1'b1;
      end
      OP_LW, OP_LB, OP_LBU, OP_LUI: begin
        bundle.op_type     = opcode;
        bundle.mem_op      = 1'b1;
        bundle.byte_op     = (opcode == OP_LB) || (opcode == OP_LBU);
        bundle.unsigned_op = (opcode == OP_LBU);
        bundle.imm_op      = (opcode == OP_LUI);
      end
      OP_SW, OP_SB: begin
        bundle.op_type  = opcode;
        bundle.mem_op   = 1'b1;
        bundle.write_op = 1'b1;
        bundle.byte_op  = (opcode == OP_SB);
      end
      OP_J, OP_JAL: begin
        bundle.op_type = opcode;
        bundle.jump_op = 1'b1;
        bundle.imm_op  = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ: begin
        bundle.op_type   = opcode;
        bundle.branch_op = 1'b1;
      end
      default: bundle.nop = 1'b1;
    endcase
    if (bundle.nop) bundle.op_type = '0;
  end

endmodule

// File: rtl/decode_queue.sv
// Buffered MIPS decode stage: instruction FIFO feeding a registered decoder.
// Optional load-use bubble insertion: define DECODE_LOAD_USE_STALL_EN.
module decode_queue
  import decode_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       w_flush,
  input  logic                       w_in_valid,
  output logic                       w_in_ready,
  input  logic [31:0]                w_in_instr_32,
  input  logic [PC_W-1:0]            w_in_pc,
  output logic                       w_out_valid,
  input  logic                       w_out_ready,
  output logic [PC_W-1:0]            w_out_pc,
  output logic [31:0]                w_out_instr_32,
  output logic                       w_alu_op,
  output logic                       w_unsigned_op,
  output logic                       w_imm_op,
  output logic                       w_byte_op,
  output logic                       w_shift_op,
  output logic                       w_mem_op,
  output logic                       w_write_op,
  output logic                       w_branch_op,
  output logic                       w_jump_op,
  output logic                       w_reg_jump_op,
  output logic                       w_nop,
  output logic [5:0]                 w_op_type_6,
  output logic [4:0]                 w_rs_addr_5,
  output logic [4:0]                 w_rt_addr_5,
  output logic [4:0]                 w_rd_addr_5,
  output logic [4:0]                 w_sh_amt_5,
  output logic [15:0]                w_alu_imm_val_16,
  output logic [25:0]                w_branch_imm_val_26,
  output logic [$clog2(DEPTH+1)-1:0] w_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  if (INSTR_W != 32) begin : g_instr_w_check
    $error("decode_queue: INSTR_W must be 32");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("decode_queue: DEPTH must be a power of two >= 2");
  end

  logic [31:0]      fifo_instr [DEPTH];
  logic [PC_W-1:0]  fifo_pc    [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic             out_valid;
  logic [PC_W-1:0]  out_pc;
  logic [31:0]      out_instr;
  decode_bundle_t   out_bundle;

  logic [31:0]      head_instr;
  decode_bundle_t   head_bundle;
  logic             full, empty, push, pop, advance, hazard;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign head_instr = fifo_instr[rd_ptr];
  assign advance    = !out_valid || w_out_ready;
  assign push       = w_in_valid && !full && !w_flush;
  assign pop        = advance && !empty && !hazard;

  decode_logic u_decode (
    .instr  (head_instr),
    .bundle (head_bundle)
  );

`ifdef DECODE_LOAD_USE_STALL_EN
  logic [4:0] load_rt;
  logic       out_is_load, head_reads;
  assign load_rt     = out_instr[20:16];
  assign out_is_load = out_bundle.mem_op && !out_bundle.write_op &&
                       (out_instr[31:26] != OP_LUI);
  assign head_reads  = (head_instr[25:21] == load_rt) ||
                       (reads_rt(head_instr) && (head_instr[20:16] == load_rt));
  assign hazard      = out_valid && out_is_load && (load_rt != '0) &&
                       !empty && head_reads;
`else
  assign hazard = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_instr[wr_ptr] <= w_in_instr_32;
      fifo_pc[wr_ptr]    <= w_in_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_instr      <= '0;
      out_bundle     <= '0;
      out_bundle.nop <= 1'b1;
    end else if (w_flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A stalled load or an empty queue loads a bubble; payload is left as-is.
      if (advance) begin
        out_valid <= pop;
        if (pop) begin
          out_pc     <= fifo_pc[rd_ptr];
          out_instr  <= head_instr;
          out_bundle <= head_bundle;
        end
      end
    end
  end

  assign w_in_ready          = !full;
  assign w_count             = count;
  assign w_out_valid         = out_valid;
  assign w_out_pc            = out_pc;
  assign w_out_instr_32      = out_instr;
  assign w_alu_op            = out_bundle.alu_op;
  assign w_unsigned_op       = out_bundle.unsigned_op;
  assign w_imm_op            = out_bundle.imm_op;
  assign w_byte_op           = out_bundle.byte_op;
  assign w_shift_op          = out_bundle.shift_op;
  assign w_mem_op            = out_bundle.mem_op;
  assign w_write_op          = out_bundle.write_op;
  assign w_branch_op         = out_bundle.branch_op;
  assign w_jump_op           = out_bundle.jump_op;
  assign w_reg_jump_op       = out_bundle.reg_jump_op;
  assign w_nop               = out_bundle.nop;
  assign w_op_type_6         = out_bundle.op_type;
  assign w_rs_addr_5         = out_instr[25:21];
  assign w_rt_addr_5         = out_instr[20:16];
  assign w_rd_addr_5         = out_instr[15:11];
  assign w_sh_amt_5          = out_instr[10:6];
  assign w_alu_imm_val_16    = out_instr[15:0];
  assign w_branch_imm_val_26 = out_instr[25:0];

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue: decode table vectors plus
// fill/stall, flush, load-use and reset-while-full sequences.
module tb_decode_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 32;

  logic        clock = 1'b0;
  logic        reset, w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [31:0] w_in_instr_32, w_out_instr_32;
  logic [PC_W-1:0] w_in_pc, w_out_pc;
  logic w_alu_op, w_unsigned_op, w_imm_op, w_byte_op, w_shift_op;
  logic w_mem_op, w_write_op, w_branch_op, w_jump_op, w_reg_jump_op, w_nop;
  logic [5:0]  w_op_type_6;
  logic [4:0]  w_rs_addr_5, w_rt_addr_5, w_rd_addr_5, w_sh_amt_5;
  logic [15:0] w_alu_imm_val_16;
  logic [25:0] w_branch_imm_val_26;
  logic [$clog2(DEPTH+1)-1:0] w_count;
  logic [10:0] flags;

  always #5 clock = ~clock;

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(32)) dut (
    .clock(clock), .reset(reset), .w_flush(w_flush),
    .w_in_valid(w_in_valid), .w_in_ready(w_in_ready),
    .w_in_instr_32(w_in_instr_32), .w_in_pc(w_in_pc),
    .w_out_valid(w_out_valid), .w_out_ready(w_out_ready),
    .w_out_pc(w_out_pc), .w_out_instr_32(w_out_instr_32),
    .w_alu_op(w_alu_op), .w_unsigned_op(w_unsigned_op), .w_imm_op(w_imm_op),
    .w_byte_op(w_byte_op), .w_shift_op(w_shift_op), .w_mem_op(w_mem_op),
    .w_write_op(w_write_op), .w_branch_op(w_branch_op), .w_jump_op(w_jump_op),
    .w_reg_jump_op(w_reg_jump_op), .w_nop(w_nop), .w_op_type_6(w_op_type_6),
    .w_rs_addr_5(w_rs_addr_5), .w_rt_addr_5(w_rt_addr_5),
    .w_rd_addr_5(w_rd_addr_5), .w_sh_amt_5(w_sh_amt_5),
    .w_alu_imm_val_16(w_alu_imm_val_16),
    .w_branch_imm_val_26(w_branch_imm_val_26), .w_count(w_count)
  );

  // {alu, unsigned, imm, byte, shift, mem, write, branch, jump, reg_jump, nop}
  assign flags = {w_alu_op, w_unsigned_op, w_imm_op, w_byte_op, w_shift_op,
                  w_mem_op, w_write_op, w_branch_op, w_jump_op, w_reg_jump_op, w_nop};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [10:0] flags;
    logic [5:0]  op_type;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{32'h00221821, 11'b11000000000, 6'h21}; // ADDU
    vecs[1]  = '{32'h00000000, 11'b00000000001, 6'h00}; // SLL shamt 0
    vecs[2]  = '{32'h00020900, 11'b10101000000, 6'h00}; // SLL shamt 4
    vecs[3]  = '{32'h04050000, 11'b00000000001, 6'h00}; // REGIMM rt=5
    vecs[4]  = '{32'h04210004, 11'b00000001000, 6'h01}; // BGEZ
    vecs[5]  = '{32'hA0A20004, 11'b00010110000, 6'h28}; // SB
    vecs[6]  = '{32'h90430008, 11'b01010100000, 6'h24}; // LBU
    vecs[7]  = '{32'h03E00008, 11'b00000000110, 6'h08}; // JR
    vecs[8]  = '{32'h24420001, 11'b11100000000, 6'h09}; // ADDIU
    vecs[9]  = '{32'h08000010, 11'b00100000100, 6'h02}; // J
    vecs[10] = '{32'hFC000000, 11'b00000000001, 6'h00}; // unknown opcode
    vecs[11] = '{32'h70430802, 11'b10000000000, 6'h1C}; // MUL
    vecs[12] = '{32'h3C011234, 11'b00100100000, 6'h0F}; // LUI
    vecs[13] = '{32'h10220003, 11'b00000001000, 6'h04}; // BEQ
    vecs[14] = '{32'h00430807, 11'b10001000000, 6'h07}; // SRAV

    reset = 1'b1; w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b1;
    w_in_instr_32 = '0; w_in_pc = '0;
    tick(); tick();
    check("reset count", w_count, 0);
    check("reset valid", w_out_valid, 0);
    check("reset flags", flags, 11'b00000000001);
    check("reset op_type", w_op_type_6, 0);
    check("reset pc", w_out_pc, 0);
    check("reset instr", w_out_instr_32, 0);
    reset = 1'b0;
    tick();
    check("in_ready after reset", w_in_ready, 1);

    // Latency: push at edge N, visible after edge N+1.
    w_in_valid = 1'b1; w_in_instr_32 = 32'h00221821; w_in_pc = 32'h80;
    tick();
    w_in_valid = 1'b0;
    check("lat not yet valid", w_out_valid, 0);
    tick();
    check("lat valid", w_out_valid, 1);
    check("lat rd", w_rd_addr_5, 3);
    check("lat rs", w_rs_addr_5, 1);
    check("lat rt", w_rt_addr_5, 2);
    check("lat pc", w_out_pc, 32'h80);
    tick();
    check("lat drained", w_out_valid, 0);

    for (int i = 0; i < 15; i++) begin
      w_in_valid = 1'b1; w_in_instr_32 = vecs[i].instr; w_in_pc = 32'h1000 + 32'(i);
      tick();
      w_in_valid = 1'b0;
      tick();
      check($sformatf("vec%0d valid", i), w_out_valid, 1);
      check($sformatf("vec%0d flags", i), flags, vecs[i].flags);
      check($sformatf("vec%0d op_type", i), w_op_type_6, vecs[i].op_type);
      check($sformatf("vec%0d instr", i), w_out_instr_32, vecs[i].instr);
    end
    tick();
    check("vec drained", w_out_valid, 0);

    // Fill with downstream stalled: one word in output register, DEPTH queued.
    w_out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      w_in_valid = 1'b1; w_in_instr_32 = 32'h24420000 + 32'(i);
      w_in_pc = 32'h100 + 32'(4 * i);
      tick();
    end
    check("full count", w_count, DEPTH);
    check("full in_ready", w_in_ready, 0);
    check("stall valid", w_out_valid, 1);
    check("stall pc", w_out_pc, 32'h100);
    w_in_instr_32 = 32'h24420005; w_in_pc = 32'h114;
    tick();
    check("full reject count", w_count, DEPTH);
    check("stall hold instr", w_out_instr_32, 32'h24420000);
    check("stall hold op_type", w_op_type_6, 6'h09);
    // Pop while full: the presented word must still be refused.
    w_out_ready = 1'b1;
    tick();
    w_in_valid = 1'b0;
    check("pop-while-full count", w_count, DEPTH - 1);
    check("drain pc1", w_out_pc, 32'h104);
    for (int i = 2; i <= DEPTH; i++) begin
      tick();
      check($sformatf("drain valid%0d", i), w_out_valid, 1);
      check($sformatf("drain pc%0d", i), w_out_pc, 32'h100 + 32'(4 * i));
    end
    tick();
    check("drain end valid", w_out_valid, 0);
    check("drain end count", w_count, 0);

    // Flush with a simultaneous push.
    w_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_in_valid = 1'b1; w_in_instr_32 = 32'h24430000 + 32'(i);
      w_in_pc = 32'h200 + 32'(4 * i);
      tick();
    end
    check("pre-flush count", w_count, 3);
    w_flush = 1'b1; w_in_instr_32 = 32'h2442ABCD; w_in_pc = 32'h300;
    tick();
    check("flush count", w_count, 0);
    check("flush valid", w_out_valid, 0);
    w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b1;
    tick();
    check("post-flush valid", w_out_valid, 0);
    check("post-flush count", w_count, 0);
    check("post-flush in_ready", w_in_ready, 1);

    // Load followed by a dependent ADDU.
    w_in_valid = 1'b1; w_in_instr_32 = 32'h8C220000; w_in_pc = 32'h400;
    tick();
    w_in_instr_32 = 32'h00411821; w_in_pc = 32'h404;
    tick();
    w_in_valid = 1'b0;
    check("lw valid", w_out_valid, 1);
    check("lw pc", w_out_pc, 32'h400);
    check("lw mem_op", w_mem_op, 1);
    tick();
`ifdef DECODE_LOAD_USE_STALL_EN
    check("load-use bubble", w_out_valid, 0);
    tick();
`endif
    check("addu valid", w_out_valid, 1);
    check("addu pc", w_out_pc, 32'h404);
    tick();
    check("load-use drained", w_out_valid, 0);

    // Reset while full and stalled.
    w_out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      w_in_valid = 1'b1; w_in_instr_32 = 32'h00221821; w_in_pc = 32'h500 + 32'(4 * i);
      tick();
    end
    w_in_valid = 1'b0;
    check("pre-reset count", w_count, DEPTH);
    reset = 1'b1;
    tick();
    check("rst2 count", w_count, 0);
    check("rst2 valid", w_out_valid, 0);
    check("rst2 flags", flags, 11'b00000000001);
    check("rst2 pc", w_out_pc, 0);
    check("rst2 instr", w_out_instr_32, 0);
    check("rst2 rd", w_rd_addr_5, 0);
    reset = 1'b0;
    tick();
    check("rst2 in_ready", w_in_ready, 1);
    check("rst2 still empty", w_out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
